// File: rtl/f_pc_fd_pkg.sv
// Shared fetch/decode definitions: branch and jump encodings, default PC window, nop word.
// Also imported by the D-stage comparator and decoder.
package f_pc_fd_pkg;

    typedef enum logic [1:0] {
        BT_NONE = 2'b00,
        BT_BEQ  = 2'b01,
        BT_BLTZ = 2'b10,
        BT_RSVD = 2'b11
    } btype_e;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_J    = 2'b01,
        JT_JR   = 2'b10,
        JT_RSVD = 2'b11
    } jtype_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_PC_HI    = 32'h0000_6FFF;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // A fetch address is bad when misaligned or outside the legal window [lo, hi].
    function automatic logic pc_bad(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_npc.sv
// Combinational next-PC selection for the fetch stage.
// Redirects come from the instruction currently in D, so the instruction in F is the delay slot.
module f_npc
    import f_pc_fd_pkg::*;
(
    input  logic        i_stall,
    input  logic [31:0] i_f_pc,
    input  logic [31:0] i_d_pc,
    input  logic [25:0] i_d_instr,
    input  logic        i_d_valid,
    input  logic [1:0]  i_d_btype,
    input  logic        i_d_cmp_result,
    input  logic [1:0]  i_d_jtype,
    input  logic [31:0] i_d_rs_fwd,
    output logic [31:0] o_npc
);

    logic [31:0] w_d_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_br_taken;

    assign w_d_pc_plus4 = i_d_pc + 32'd4;
    assign w_br_target  = w_d_pc_plus4 + {{14{i_d_instr[15]}}, i_d_instr[15:0], 2'b00};
    assign w_j_target   = {w_d_pc_plus4[31:28], i_d_instr[25:0], 2'b00};
    assign w_br_taken   = i_d_cmp_result &&
                          ((i_d_btype == BT_BEQ) || (i_d_btype == BT_BLTZ));

    // NOTE: o_npc gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        o_npc = i_f_pc + 32'd4;
        if (i_stall) begin
            o_npc = i_f_pc;
        end else if (i_d_valid) begin
            if (w_br_taken) begin
                o_npc = w_br_target;
            end else if (i_d_jtype == JT_J) begin
                o_npc = w_j_target;
            end else if (i_d_jtype == JT_JR) begin
                o_npc = i_d_rs_fwd;
            end
        end
    end

endmodule

// File: rtl/f_pc_fd.sv
// Fetch PC register and F/D pipeline register with address-error tagging.
// Bad fetch addresses enter D as a nop with D_adel set.
module f_pc_fd
    import f_pc_fd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_HI    = DEF_PC_HI
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [31:0] imem_instr,
    input  logic [1:0]  D_btype,
    input  logic        D_cmp_result,
    input  logic [1:0]  D_jtype,
    input  logic [31:0] D_rs_fwd,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_valid,
    output logic        D_adel
);

    logic [31:0] r_f_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic        r_d_valid;
    logic        r_d_adel;
    logic [31:0] w_npc;
    logic        w_adel;

    assign w_adel = pc_bad(r_f_pc, RESET_PC, PC_HI);

    f_npc u_f_npc (
        .i_stall        (stall),
        .i_f_pc         (r_f_pc),
        .i_d_pc         (r_d_pc),
        .i_d_instr      (r_d_instr[25:0]),
        .i_d_valid      (r_d_valid),
        .i_d_btype      (D_btype),
        .i_d_cmp_result (D_cmp_result),
        .i_d_jtype      (D_jtype),
        .i_d_rs_fwd     (D_rs_fwd),
        .o_npc          (w_npc)
    );

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_pc    <= RESET_PC;
            r_d_instr <= NOP_INSTR;
            r_d_pc    <= 32'h0;
            r_d_valid <= 1'b0;
            r_d_adel  <= 1'b0;
        end else begin
            r_f_pc <= w_npc;
            if (!stall) begin
                r_d_instr <= w_adel ? NOP_INSTR : imem_instr;
                r_d_pc    <= r_f_pc;
                r_d_valid <= 1'b1;
                r_d_adel  <= w_adel;
            end
        end
    end

    assign F_pc    = r_f_pc;
    assign D_instr = r_d_instr;
    assign D_pc    = r_d_pc;
    assign D_valid = r_d_valid;
    assign D_adel  = r_d_adel;

endmodule

// File: tb/tb_f_pc_fd.sv
// Self-checking bench for f_pc_fd: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch/decode boundary.
module tb_f_pc_fd;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HI_PC  = 32'h0000_6FFF;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [31:0] imem_instr;
    logic [1:0]  D_btype;
    logic        D_cmp_result;
    logic [1:0]  D_jtype;
    logic [31:0] D_rs_fwd;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic        D_valid;
    logic        D_adel;

    int n_checks;
    int n_errors;

    logic [31:0] m_f_pc;
    logic [31:0] m_d_instr;
    logic [31:0] m_d_pc;
    logic        m_d_valid;
    logic        m_d_adel;

    f_pc_fd dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .imem_instr   (imem_instr),
        .D_btype      (D_btype),
        .D_cmp_result (D_cmp_result),
        .D_jtype      (D_jtype),
        .D_rs_fwd     (D_rs_fwd),
        .F_pc         (F_pc),
        .D_instr      (D_instr),
        .D_pc         (D_pc),
        .D_valid      (D_valid),
        .D_adel       (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".F_pc"},    F_pc,           m_f_pc);
        check({tag, ".D_instr"}, D_instr,        m_d_instr);
        check({tag, ".D_pc"},    D_pc,           m_d_pc);
        check({tag, ".D_valid"}, 32'(D_valid),   32'(m_d_valid));
        check({tag, ".D_adel"},  32'(D_adel),    32'(m_d_adel));
    endtask

    task automatic model_reset();
        m_f_pc    = RST_PC;
        m_d_instr = 32'h0;
        m_d_pc    = 32'h0;
        m_d_valid = 1'b0;
        m_d_adel  = 1'b0;
    endtask

    // Next fetch address from the architectural rules, computed with plain arithmetic.
    function automatic logic [31:0] model_npc();
        int signed   imm;
        logic [31:0] link;
        if (stall) return m_f_pc;
        if (m_d_valid) begin
            link = m_d_pc + 32'd4;
            if ((D_btype == 2'b01 || D_btype == 2'b10) && D_cmp_result) begin
                imm = int'($signed(m_d_instr[15:0]));
                return link + 32'(imm * 4);
            end
            if (D_jtype == 2'b01)
                return (link & 32'hF000_0000) | ({6'b0, m_d_instr[25:0]} * 32'd4);
            if (D_jtype == 2'b10)
                return D_rs_fwd;
        end
        return m_f_pc + 32'd4;
    endfunction

    task automatic idle_inputs();
        stall        = 1'b0;
        D_btype      = 2'b00;
        D_cmp_result = 1'b0;
        D_jtype      = 2'b00;
        D_rs_fwd     = 32'h0;
        imem_instr   = $urandom;
    endtask

    // One clock edge: predict, clock, then compare away from the edge.
    task automatic step(input string tag);
        logic [31:0] nxt_pc;
        logic        bad;
        nxt_pc = model_npc();
        if (!stall) begin
            bad = (m_f_pc % 4 != 0) || (m_f_pc < RST_PC) || (m_f_pc > HI_PC);
            m_d_instr = bad ? 32'h0 : imem_instr;
            m_d_pc    = m_f_pc;
            m_d_valid = 1'b1;
            m_d_adel  = bad;
        end
        m_f_pc = nxt_pc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset_n = 1'b1;
    endtask

    logic [31:0] saved_pc;
    logic [31:0] saved_dpc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Sequential fetch after reset release.
        step("seq1");
        step("seq2");
        step("seq3");
        check("seq_pc_300c", F_pc, 32'h0000_300C);
        check("seq_dpc_3008", D_pc, 32'h0000_3008);

        // Taken beq with offset -1 at D_pc=3004: delay slot 3008 enters D, F goes back to 3004.
        pulse_reset("rst_beq");
        step("beq_a");
        imem_instr = 32'h1000_FFFF;
        step("beq_b");
        check("beq_dpc", D_pc, 32'h0000_3004);
        imem_instr = 32'h1234_5678;
        D_btype = 2'b01; D_cmp_result = 1'b1;
        step("beq_c");
        check("beq_slot_dpc", D_pc, 32'h0000_3008);
        check("beq_target", F_pc, 32'h0000_3004);

        // Not-taken bltz at D_pc=3010.
        pulse_reset("rst_bltz");
        idle_inputs();
        repeat (5) step("bltz_pre");
        check("bltz_dpc", D_pc, 32'h0000_3010);
        D_btype = 2'b10; D_cmp_result = 1'b0;
        step("bltz");
        check("bltz_seq", F_pc, 32'h0000_3018);

        // jr to a misaligned target: loaded, then flagged with a nop on capture.
        pulse_reset("rst_jr");
        idle_inputs();
        step("jr_a");
        D_jtype = 2'b10; D_rs_fwd = 32'h0000_3002;
        step("jr_b");
        check("jr_target", F_pc, 32'h0000_3002);
        idle_inputs();
        imem_instr = 32'hDEAD_BEEF;
        step("jr_c");
        check("jr_adel", 32'(D_adel), 32'd1);
        check("jr_nop", D_instr, 32'h0);

        // Stall for two cycles across a taken branch.
        pulse_reset("rst_stall");
        idle_inputs();
        imem_instr = 32'h1000_0010;
        step("st_a");
        saved_pc  = F_pc;
        saved_dpc = D_pc;
        stall = 1'b1; D_btype = 2'b01; D_cmp_result = 1'b1;
        step("st_b");
        step("st_c");
        check("stall_pc_frozen", F_pc, saved_pc);
        check("stall_dpc_frozen", D_pc, saved_dpc);
        stall = 1'b0;
        step("st_d");
        check("stall_redirect", F_pc, 32'h0000_3044);

        // Async reset while F_pc=3100 during a stall.
        pulse_reset("rst_async_pre");
        idle_inputs();
        step("ar_a");
        D_jtype = 2'b10; D_rs_fwd = 32'h0000_3100;
        step("ar_b");
        check("ar_at_3100", F_pc, 32'h0000_3100);
        stall = 1'b1;
        pulse_reset("ar_pulse");
        check("ar_pc_now", F_pc, RST_PC);
        check("ar_valid_now", 32'(D_valid), 32'd0);
        idle_inputs();
        step("ar_first");
        check("ar_first_capture", D_pc, RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 3) == 0);
            D_btype      = 2'($urandom_range(0, 3));
            D_cmp_result = 1'($urandom_range(0, 1));
            D_jtype      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            D_rs_fwd     = RST_PC + 32'($urandom_range(0, 32'h4100));
            if ($urandom_range(0, 3) != 0) D_rs_fwd[1:0] = 2'b00;
            imem_instr   = $urandom;
            if ($urandom_range(0, 1) == 0) imem_instr[15:8] = {8{imem_instr[15]}};
            if ($urandom_range(0, 60) == 0) pulse_reset("rnd_rst");
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/f_pc_fd.md
F_PC_FD -- requirements
Module: f_pc_fd

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter PC_HI, default 32'h0000_6FFF, highest legal fetch address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard-unit hold request for the PC and the F/D register.
REQ-006 imem_instr  input  32  instruction memory word at F_pc, combinational.
REQ-007 D_btype  input  2  branch type of the D instruction: 00 none, 01 beq, 10 bltz, 11 reserved (treated as none).
REQ-008 D_cmp_result  input  1  branch condition from the D-stage comparator; 1 means taken.
REQ-009 D_jtype  input  2  jump type of the D instruction: 00 none, 01 j/jal, 10 jr/jalr, 11 reserved (treated as none).
REQ-010 D_rs_fwd  input  32  forwarded rs value, used as the jr/jalr target.
REQ-011 F_pc  output  32  current fetch address.
REQ-012 D_instr  output  32  instruction registered into D.
REQ-013 D_pc  output  32  PC of D_instr.
REQ-014 D_valid  output  1  D_instr came from a real fetch since reset.
REQ-015 D_adel  output  1  D_pc was misaligned or outside [RESET_PC, PC_HI] when fetched.

Function
REQ-016 Next-PC selection SHALL use this priority:
- stall=1: hold F_pc.
- D_btype in {01,10} and D_cmp_result=1: D_pc+4+(sign-extended D_instr[15:0] shifted left 2).
- D_jtype=01: {D_pc_plus4[31:28], D_instr[25:0], 2'b00}.
- D_jtype=10: D_rs_fwd.
- otherwise: F_pc+4.
REQ-017 A branch or jump with D_valid=0 SHALL NOT redirect; F_pc+4 applies.
REQ-018 Redirects SHALL take effect on the edge after the D instruction is present, so the instruction then in F is the delay slot; it SHALL NOT be flushed.
REQ-019 When stall=0, the F/D register SHALL capture on each edge: D_instr<=imem_instr, D_pc<=F_pc, D_valid<=1, D_adel<=misaligned or out-of-range F_pc.
REQ-020 When stall=1, F_pc, D_instr, D_pc, D_valid and D_adel SHALL all hold their values.
REQ-021 When D_adel is computed as 1, D_instr SHALL be captured as 32'h0 (nop) instead of imem_instr.
REQ-022 All PC arithmetic SHALL be 32-bit modulo 2^32; wrap-around SHALL NOT be flagged except through the range check.
REQ-023 Fetch-to-D latency SHALL be 1 cycle; the branch decision SHALL use no added register stage.
REQ-024 A jr/jalr target with bits [1:0] nonzero SHALL still be loaded into F_pc and flagged through D_adel on the following capture.

Reset
REQ-025 While reset_n=0 (asynchronous): F_pc=RESET_PC, D_instr=0, D_pc=0, D_valid=0, D_adel=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL override both; after release, the first capture SHALL be at RESET_PC.

Structure
REQ-027 A shared package SHALL hold the btype/jtype encodings, RESET_PC, PC_HI and the nop constant, common with the D-stage comparator and decoder.
REQ-028 The combinational next-PC logic SHALL be one sub-module, f_npc; the PC and F/D registers stay in f_pc_fd.

Verification
REQ-029 Reset release, no stall, 3 edges -> F_pc goes 3000, 3004, 3008, 300C; D_pc trails by 1 cycle; D_valid=1 from the first edge.
REQ-030 beq at D_pc=3004 with imm=16'hFFFF and cmp=1 -> delay slot 3008 enters D; next F_pc=3004.
REQ-031 bltz at D_pc=3010 with cmp=0 -> sequential F_pc+4; no redirect.
REQ-032 jr with D_rs_fwd=32'h3002 -> F_pc=3002; next capture gives D_adel=1 and D_instr=0.
REQ-033 stall held 2 cycles during a taken branch -> all outputs frozen; redirect applies on the first unstalled edge.
REQ-034 reset_n pulsed low between edges while F_pc=3100 -> F_pc=3000 immediately; D_valid=0.
